// File: rtl/if_stage_pkg.sv
// Shared definitions for the RiSC-16 instruction-fetch stage: word width,
// opcodes, the default reset PC, fetch FSM encodings and the HALT decode.
package if_stage_pkg;

    localparam int WORD_LEN = 16;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    localparam logic [WORD_LEN-1:0] DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        IF_FETCH  = 2'd0,
        IF_HOLD   = 2'd1,
        IF_FLUSH  = 2'd2,
        IF_HALTED = 2'd3
    } if_state_t;

    // HALT is encoded as a JALR whose low seven bits are non-zero.
    function automatic logic is_halt(input logic [WORD_LEN-1:0] word);
        return (word[15:13] == OP_JALR) && (word[6:0] != 7'd0);
    endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter register: loads an explicit target or increments
// (wrapping modulo 2^WORD_LEN) when enabled.
module pc_reg #(
    parameter int                WORD_LEN = 16,
    parameter logic [WORD_LEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_en,
    input  logic                sel_load,
    input  logic [WORD_LEN-1:0] load_val,
    output logic [WORD_LEN-1:0] pc
);

    // Update PC on enable: explicit target when sel_load, else pc+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load_en) begin
            pc <= sel_load ? load_val : pc + WORD_LEN'(1);
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage of the non-pipelined RiSC-16 core.
// Handshakes: imem side is req/ack -- imem_req stays high with imem_addr
// frozen until the cycle imem_ack is high, and imem_rdata is taken only in
// that cycle. Decode side is valid/ready -- instr_valid stays high with
// instr/pc_out/pc_plus1 frozen until the cycle instr_ready is high, which
// is the cycle of transfer.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int                  WORD_LEN = if_stage_pkg::WORD_LEN,
    parameter logic [WORD_LEN-1:0] RESET_PC = if_stage_pkg::DEFAULT_RESET_PC
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [WORD_LEN-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [WORD_LEN-1:0] imem_rdata,
    output logic [WORD_LEN-1:0] instr,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [WORD_LEN-1:0] pc_out,
    output logic [WORD_LEN-1:0] pc_plus1,
    input  logic                redirect,
    input  logic [WORD_LEN-1:0] redirect_pc,
    output logic                halted,
    output logic [1:0]          dbg_state
);

    if_state_t           state;
    logic [WORD_LEN-1:0] pc;
    logic [WORD_LEN-1:0] redirect_target;
    logic                pc_load;
    logic                pc_sel_load;
    logic [WORD_LEN-1:0] pc_din;
    logic                ack;

    // The request register comes out of reset low, so the first cycle after
    // release is idle; an ack is only meaningful while a request is up.
    assign ack = imem_ack & imem_req;

    pc_reg #(
        .WORD_LEN (WORD_LEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_en  (pc_load),
        .sel_load (pc_sel_load),
        .load_val (pc_din),
        .pc       (pc)
    );

    assign imem_addr = pc;
    assign pc_out    = pc;
    assign pc_plus1  = pc + WORD_LEN'(1);
    assign dbg_state = state;

    // PC update selection: redirect targets, flush completion, or increment on accept.
    always_comb begin
        pc_load     = 1'b0;
        pc_sel_load = 1'b1;
        pc_din      = redirect_pc;
        case (state)
            IF_FETCH: begin
                // With a live request the address may only move on ack;
                // before the first request there is no transaction to protect.
                if (redirect && (ack || !imem_req)) begin
                    pc_load = 1'b1;
                end
            end
            IF_FLUSH: begin
                if (ack) begin
                    pc_load = 1'b1;
                    pc_din  = redirect ? redirect_pc : redirect_target;
                end
            end
            IF_HOLD: begin
                if (redirect) begin
                    pc_load = 1'b1;
                end else if (instr_ready && !is_halt(instr)) begin
                    pc_load     = 1'b1;
                    pc_sel_load = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Fetch FSM with instruction register, flush target and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IF_FETCH;
            instr           <= '0;
            redirect_target <= '0;
            imem_req        <= 1'b0;
            instr_valid     <= 1'b0;
            halted          <= 1'b0;
        end else begin
            case (state)
                IF_FETCH: begin
                    imem_req <= 1'b1;
                    if (ack && !redirect) begin
                        instr       <= imem_rdata;
                        state       <= IF_HOLD;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end else if (!ack && redirect && imem_req) begin
                        redirect_target <= redirect_pc;
                        state           <= IF_FLUSH;
                    end
                end
                IF_FLUSH: begin
                    if (redirect) begin
                        redirect_target <= redirect_pc;
                    end
                    if (ack) begin
                        state <= IF_FETCH;
                    end
                end
                IF_HOLD: begin
                    if (redirect || (instr_ready && !is_halt(instr))) begin
                        state       <= IF_FETCH;
                        imem_req    <= 1'b1;
                        instr_valid <= 1'b0;
                    end else if (instr_ready) begin
                        state       <= IF_HALTED;
                        instr_valid <= 1'b0;
                        halted      <= 1'b1;
                    end
                end
                IF_HALTED: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    halted      <= 1'b1;
                end
                default: begin
                    state <= IF_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: behavioural instruction memory with
// programmable ack latency, fixed vectors with hand-computed expectations.
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] pc_out;
    logic [15:0] pc_plus1;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halted;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    if_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_out      (pc_out),
        .pc_plus1    (pc_plus1),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted),
        .dbg_state   (dbg_state)
    );

    // instruction memory: ack after mem_lat waiting cycles of a held request
    logic [15:0] mem [0:255];
    int          mem_lat;
    int          wait_cnt;

    assign imem_ack   = imem_req && (wait_cnt >= mem_lat);
    assign imem_rdata = mem[imem_addr[7:0]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !imem_req || imem_ack) wait_cnt <= 0;
        else                                 wait_cnt <= wait_cnt + 1;
    end

    // checker
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    // Leaves the bench at t0: first cycle with the request up after release.
    task automatic do_reset();
        rst_n       = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        mem_lat     = 0;
        clear_mem();
        #2;

        // ---- reset state
        check("rst_req",    {15'd0, imem_req},    16'h0000);
        check("rst_valid",  {15'd0, instr_valid}, 16'h0000);
        check("rst_halted", {15'd0, halted},      16'h0000);
        check("rst_instr",  instr,                16'h0000);
        check("rst_pc",     pc_out,               16'h0000);

        // ---- zero-wait fetch of two words, decode always ready
        mem[0] = 16'h2481;
        mem[1] = 16'h0000;
        do_reset();
        instr_ready = 1'b1;
        check("zw_req0",  {15'd0, imem_req}, 16'h0001);
        check("zw_addr0", imem_addr,         16'h0000);
        tick();
        check("zw_valid0", {15'd0, instr_valid}, 16'h0001);
        check("zw_instr0", instr,                16'h2481);
        check("zw_pc0",    pc_out,               16'h0000);
        check("zw_pcp1_0", pc_plus1,             16'h0001);
        tick();
        check("zw_addr1",  imem_addr,            16'h0001);
        check("zw_valid1", {15'd0, instr_valid}, 16'h0000);
        tick();
        check("zw_instr1", instr,  16'h0000);
        check("zw_pc1",    pc_out, 16'h0001);
        instr_ready = 1'b0;

        // ---- 3-cycle memory, decode stalls 4 cycles
        clear_mem();
        mem[0]  = 16'h1234;
        mem_lat = 3;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check("lat_addr",  imem_addr,            16'h0000);
            check("lat_req",   {15'd0, imem_req},    16'h0001);
            check("lat_valid", {15'd0, instr_valid}, 16'h0000);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            check("stall_valid", {15'd0, instr_valid}, 16'h0001);
            check("stall_instr", instr,                16'h1234);
            check("stall_pc",    pc_out,               16'h0000);
            tick();
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("stall_inc_addr", imem_addr,            16'h0001);
        check("stall_inc_req",  {15'd0, imem_req},    16'h0001);
        check("stall_inc_vld",  {15'd0, instr_valid}, 16'h0000);

        // ---- redirect during a pending fetch at 0005 -> flush to 0040
        clear_mem();
        mem[8'h05] = 16'hAAAA;
        mem[8'h40] = 16'h5555;
        mem_lat    = 0;
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 16'h0005;
        tick();
        mem_lat     = 3;
        redirect_pc = 16'h0040;
        check("fl_addr5", imem_addr, 16'h0005);
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("fl_state", {14'd0, dbg_state},    {14'd0, IF_FLUSH});
            check("fl_addr",  imem_addr,             16'h0005);
            check("fl_valid", {15'd0, instr_valid},  16'h0000);
            tick();
        end
        check("fl_target", imem_addr,         16'h0040);
        check("fl_req",    {15'd0, imem_req}, 16'h0001);
        for (int i = 0; i < 4; i++) begin
            check("fl_novalid", {15'd0, instr_valid}, 16'h0000);
            tick();
        end
        check("fl_valid40", {15'd0, instr_valid}, 16'h0001);
        check("fl_instr40", instr,                16'h5555);
        check("fl_pc40",    pc_out,               16'h0040);

        // ---- PC FFFF: redirect beats accept, then plain wrap
        clear_mem();
        mem[8'hFF] = 16'h0001;
        mem[8'h10] = 16'h0002;
        mem_lat    = 0;
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        tick();
        redirect = 1'b0;
        check("wr_addr", imem_addr, 16'hFFFF);
        tick();
        check("wr_pc",    pc_out,               16'hFFFF);
        check("wr_pcp1",  pc_plus1,             16'h0000);
        check("wr_valid", {15'd0, instr_valid}, 16'h0001);
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        tick();
        check("wr_redir", imem_addr, 16'h0010);
        instr_ready = 1'b0;
        redirect_pc = 16'hFFFF;
        tick();
        redirect = 1'b0;
        tick();
        check("wr_pc2", pc_out, 16'hFFFF);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("wr_wrap",     imem_addr,         16'h0000);
        check("wr_wrap_req", {15'd0, imem_req}, 16'h0001);

        // ---- HALT: stops fetch, ignores redirect, reset resumes
        clear_mem();
        mem[0]  = 16'hE001;
        mem_lat = 0;
        do_reset();
        instr_ready = 1'b1;
        tick();
        check("ht_instr", instr, 16'hE001);
        tick();
        instr_ready = 1'b0;
        check("ht_halted", {15'd0, halted},      16'h0001);
        check("ht_req",    {15'd0, imem_req},    16'h0000);
        check("ht_valid",  {15'd0, instr_valid}, 16'h0000);
        check("ht_pc",     pc_out,               16'h0000);
        redirect    = 1'b1;
        redirect_pc = 16'h0030;
        tick();
        redirect = 1'b0;
        tick();
        check("ht_ign_halt", {15'd0, halted},   16'h0001);
        check("ht_ign_req",  {15'd0, imem_req}, 16'h0000);
        check("ht_ign_pc",   pc_out,            16'h0000);
        rst_n = 1'b0;
        #1;
        check("ht_rst_halt", {15'd0, halted}, 16'h0000);
        do_reset();
        check("ht_resume_req",  {15'd0, imem_req}, 16'h0001);
        check("ht_resume_addr", imem_addr,         16'h0000);

        // ---- reset asserted during FLUSH
        clear_mem();
        mem[0]  = 16'h1111;
        mem_lat = 3;
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 16'h0020;
        tick();
        redirect = 1'b0;
        check("rf_state", {14'd0, dbg_state}, {14'd0, IF_FLUSH});
        check("rf_req",   {15'd0, imem_req},  16'h0001);
        rst_n = 1'b0;
        #1;
        check("rf_req0",   {15'd0, imem_req},    16'h0000);
        check("rf_valid0", {15'd0, instr_valid}, 16'h0000);
        check("rf_halt0",  {15'd0, halted},      16'h0000);
        do_reset();
        check("rf_addr", imem_addr,         16'h0000);
        check("rf_req1", {15'd0, imem_req}, 16'h0001);
        for (int i = 0; i < 4; i++) tick();
        check("rf_valid", {15'd0, instr_valid}, 16'h0001);
        check("rf_instr", instr,                16'h1111);
        check("rf_pc",    pc_out,               16'h0000);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
